// File: rtl/qa_drv_prim_conflict_gate_pkg.sv
// Shared types and the address-to-bucket hash for the QA driver conflict gate
// and its counting filter.
package qa_drv_prim_conflict_gate_pkg;

   localparam int N_BUCKETS_DEF = 16;
   localparam int N_TAGS_DEF    = 16;
   localparam int HASH_MAX_W    = 16;

   typedef logic [$clog2(N_BUCKETS_DEF)-1:0] t_bucket_idx;
   typedef logic [$clog2(N_TAGS_DEF)-1:0]    t_tag;

   // XOR of all bucket_w-wide chunks from bit 0; addr arrives zero-extended,
   // which supplies the padding of the last partial chunk.
   function automatic logic [HASH_MAX_W-1:0] bucket_hash(input logic [63:0] addr,
                                                         input int addr_w,
                                                         input int bucket_w);
      logic [63:0] mask;
      logic [63:0] acc;
      mask = (64'd1 << bucket_w) - 64'd1;
      acc  = '0;
      for (int c = 0; c < 64; c++) begin
         if (c * bucket_w < addr_w) begin
            acc = acc ^ ((addr >> (c * bucket_w)) & mask);
         end
      end
      return acc[HASH_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/qa_drv_prim_conflict_gate_fifo.sv
// In-order request FIFO with registered full/empty flags.
module qa_drv_prim_conflict_gate_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);
   import qa_drv_prim_conflict_gate_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[rptr];

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop) begin
         count_nxt = count + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
         count_nxt = count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == FULL_CNT);
         empty <= (count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= push_data;
   end

endmodule

// File: rtl/qa_drv_prim_conflict_gate.sv
// Ordering gate ahead of the counting filter: issues the FIFO head only when it
// cannot reorder against an in-flight access to the same bucket.
module qa_drv_prim_conflict_gate #(
   parameter int ADDR_WIDTH = 32,
   parameter int N_BUCKETS  = 16,
   parameter int N_TAGS     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [ADDR_WIDTH-1:0]        req_addr,
   input  logic                         req_isWrite,
   input  logic                         req_valid,
   output logic                         req_ready,
   output logic [ADDR_WIDTH-1:0]        out_addr,
   output logic                         out_isWrite,
   output logic [$clog2(N_TAGS)-1:0]    out_tag,
   output logic                         out_valid,
   input  logic                         out_ready,
   input  logic [$clog2(N_TAGS)-1:0]    rsp_tag,
   input  logic                         rsp_valid,
   output logic [$clog2(N_BUCKETS)-1:0] flt_test_req,
   input  logic                         flt_test_notFull,
   input  logic                         flt_test_isZero,
   output logic [$clog2(N_BUCKETS)-1:0] flt_insert,
   output logic                         flt_insert_en,
   output logic [$clog2(N_BUCKETS)-1:0] flt_remove,
   output logic                         flt_remove_en,
   output logic                         err_badTag
);
   import qa_drv_prim_conflict_gate_pkg::*;

   localparam int BW = $clog2(N_BUCKETS);
   localparam int TW = $clog2(N_TAGS);
   localparam int FW = ADDR_WIDTH + 1;

   logic [FW-1:0]         head_p0;
   logic                  vld_p0;
   logic [ADDR_WIDTH-1:0] addr_p0;
   logic                  wr_p0;
   logic [BW-1:0]         bkt_p0;
   logic                  fifo_full;
   logic                  fifo_empty;

   logic [N_TAGS-1:0]     tag_vld;
   logic [N_TAGS-1:0]     tag_wr;
   logic [BW-1:0]         tag_bkt [N_TAGS];
   logic [N_BUCKETS-1:0]  wr_pend;
   logic                  free_any;
   logic [TW-1:0]         free_tag;

   logic                  can_out;
   logic                  hazard_ok;
   logic                  issue;
   logic                  rsp_hit;

   logic                  vld_p1;
   logic [ADDR_WIDTH-1:0] addr_p1;
   logic                  wr_p1;
   logic [TW-1:0]         tag_p1;

   qa_drv_prim_conflict_gate_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (req_valid),
      .push_data ({req_isWrite, req_addr}),
      .pop       (issue),
      .head_data (head_p0),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Stage p0: FIFO head, bucket hash and issue decision
   assign vld_p0  = !fifo_empty;
   assign addr_p0 = head_p0[ADDR_WIDTH-1:0];
   assign wr_p0   = head_p0[ADDR_WIDTH];

   always_comb begin
      bkt_p0 = BW'(bucket_hash(64'(addr_p0), ADDR_WIDTH, BW));
   end

   always_comb begin
      free_any = 1'b0;
      free_tag = '0;
      for (int t = N_TAGS - 1; t >= 0; t--) begin
         if (!tag_vld[t]) begin
            free_any = 1'b1;
            free_tag = TW'(t);
         end
      end
   end

   // Reads may share a bucket with other reads but never pass a pending write;
   // writes wait until the bucket has drained completely.
   assign can_out   = !vld_p1 || out_ready;
   assign hazard_ok = wr_p0 ? flt_test_isZero : (flt_test_notFull && !wr_pend[bkt_p0]);
   assign issue     = !reset && vld_p0 && free_any && can_out && hazard_ok;
   assign rsp_hit   = rsp_valid && tag_vld[rsp_tag];

   assign req_ready     = !reset && !fifo_full;
   assign flt_test_req  = vld_p0 ? bkt_p0 : '0;
   assign flt_insert_en = issue;
   assign flt_insert    = issue ? bkt_p0 : '0;
   assign flt_remove_en = rsp_hit;
   assign flt_remove    = rsp_hit ? tag_bkt[rsp_tag] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_vld    <= '0;
         wr_pend    <= '0;
         err_badTag <= 1'b0;
      end else begin
         if (issue) begin
            tag_vld[free_tag] <= 1'b1;
            if (wr_p0) wr_pend[bkt_p0] <= 1'b1;
         end
         if (rsp_hit) begin
            tag_vld[rsp_tag] <= 1'b0;
            if (tag_wr[rsp_tag]) wr_pend[tag_bkt[rsp_tag]] <= 1'b0;
         end
         if (rsp_valid && !rsp_hit) err_badTag <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (issue) begin
         tag_bkt[free_tag] <= bkt_p0;
         tag_wr[free_tag]  <= wr_p0;
      end
   end

   // Stage p1: output register, held while stalled
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         addr_p1 <= '0;
         wr_p1   <= 1'b0;
         tag_p1  <= '0;
      end else if (issue) begin
         vld_p1  <= 1'b1;
         addr_p1 <= addr_p0;
         wr_p1   <= wr_p0;
         tag_p1  <= free_tag;
      end else if (out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign out_valid   = vld_p1;
   assign out_addr    = addr_p1;
   assign out_isWrite = wr_p1;
   assign out_tag     = tag_p1;

endmodule

// File: tb/tb_qa_drv_prim_conflict_gate.sv
// Directed bench for the conflict gate with a small counting-filter model as environment.
module tb_qa_drv_prim_conflict_gate;
   import qa_drv_prim_conflict_gate_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] req_addr;
   logic        req_isWrite;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] out_addr;
   logic        out_isWrite;
   t_tag        out_tag;
   logic        out_valid;
   logic        out_ready;
   t_tag        rsp_tag;
   logic        rsp_valid;
   t_bucket_idx flt_test_req;
   logic        flt_test_notFull;
   logic        flt_test_isZero;
   t_bucket_idx flt_insert;
   logic        flt_insert_en;
   t_bucket_idx flt_remove;
   logic        flt_remove_en;
   logic        err_badTag;

   int n_checks = 0;
   int n_errors = 0;
   int fcnt [16];

   qa_drv_prim_conflict_gate dut (
      .clk              (clk),
      .reset            (reset),
      .req_addr         (req_addr),
      .req_isWrite      (req_isWrite),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .out_addr         (out_addr),
      .out_isWrite      (out_isWrite),
      .out_tag          (out_tag),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .rsp_tag          (rsp_tag),
      .rsp_valid        (rsp_valid),
      .flt_test_req     (flt_test_req),
      .flt_test_notFull (flt_test_notFull),
      .flt_test_isZero  (flt_test_isZero),
      .flt_insert       (flt_insert),
      .flt_insert_en    (flt_insert_en),
      .flt_remove       (flt_remove),
      .flt_remove_en    (flt_remove_en),
      .err_badTag       (err_badTag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counting filter environment: per-bucket counts driven by insert/remove.
   always @(posedge clk) begin
      for (int i = 0; i < 16; i++) begin
         if (reset) fcnt[i] <= 0;
         else fcnt[i] <= fcnt[i] + ((flt_insert_en && flt_insert == 4'(i)) ? 1 : 0)
                                 - ((flt_remove_en && flt_remove == 4'(i)) ? 1 : 0);
      end
   end

   always_comb begin
      flt_test_isZero  = (fcnt[flt_test_req] == 0);
      flt_test_notFull = (fcnt[flt_test_req] < 15);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic free_tags(input int n);
      for (int t = 0; t < n; t++) begin
         rsp_tag   = 4'(t);
         rsp_valid = 1'b1;
         tick();
      end
      rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (flt_insert_en !== 1'b0) begin n_errors++; $display("FAIL rst_insert_en: got %b expected 0", flt_insert_en); end
      n_checks++; if (flt_remove_en !== 1'b0) begin n_errors++; $display("FAIL rst_remove_en: got %b expected 0", flt_remove_en); end
      n_checks++; if (err_badTag !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b expected 0", err_badTag); end
      tick();
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready_after: got %b expected 1", req_ready); end
      tick();
   endtask

   task automatic test_basic_read();
      req_addr = 32'h10; req_isWrite = 1'b0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (flt_insert_en !== 1'b1) begin n_errors++; $display("FAIL basic_insert_en: got %b expected 1", flt_insert_en); end
      n_checks++; if (flt_insert !== 4'd1) begin n_errors++; $display("FAIL basic_insert: got %0d expected 1", flt_insert); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_out_early: got %b expected 0", out_valid); end
      tick();
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
      n_checks++; if (out_tag !== 4'd0) begin n_errors++; $display("FAIL basic_out_tag: got %0d expected 0", out_tag); end
      n_checks++; if (out_addr !== 32'h10) begin n_errors++; $display("FAIL basic_out_addr: got %h expected 10", out_addr); end
      n_checks++; if (out_isWrite !== 1'b0) begin n_errors++; $display("FAIL basic_out_wr: got %b expected 0", out_isWrite); end
      tick();
      rsp_tag = 4'd0; rsp_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (flt_remove_en !== 1'b1) begin n_errors++; $display("FAIL basic_remove_en: got %b expected 1", flt_remove_en); end
      n_checks++; if (flt_remove !== 4'd1) begin n_errors++; $display("FAIL basic_remove: got %0d expected 1", flt_remove); end
      tick();
      rsp_valid = 1'b0;
      req_addr = 32'h12345678; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (flt_test_req !== 4'd8) begin n_errors++; $display("FAIL hash_test_req: got %0d expected 8", flt_test_req); end
      n_checks++; if (flt_insert !== 4'd8) begin n_errors++; $display("FAIL hash_insert: got %0d expected 8", flt_insert); end
      tick();
      @(negedge clk);
      n_checks++; if (out_tag !== 4'd0) begin n_errors++; $display("FAIL basic_reuse_tag: got %0d expected 0", out_tag); end
      tick();
      free_tags(1);
   endtask

   task automatic test_write_after_write();
      req_addr = 32'h10; req_isWrite = 1'b1; req_valid = 1'b1;
      tick();
      req_addr = 32'h0011_0010;
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (flt_test_req !== 4'd1) begin n_errors++; $display("FAIL waw_test_req: got %0d expected 1", flt_test_req); end
      n_checks++; if (flt_insert_en !== 1'b0) begin n_errors++; $display("FAIL waw_held: got %b expected 0", flt_insert_en); end
      n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL waw_ready: got %b expected 1", req_ready); end
      repeat (3) tick();
      @(negedge clk);
      n_checks++; if (flt_insert_en !== 1'b0) begin n_errors++; $display("FAIL waw_still_held: got %b expected 0", flt_insert_en); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL waw_no_out: got %b expected 0", out_valid); end
      tick();
      rsp_tag = 4'd0; rsp_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (flt_remove_en !== 1'b1) begin n_errors++; $display("FAIL waw_remove_en: got %b expected 1", flt_remove_en); end
      n_checks++; if (flt_insert_en !== 1'b0) begin n_errors++; $display("FAIL waw_rsp_cycle: got %b expected 0", flt_insert_en); end
      tick();
      rsp_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (flt_insert_en !== 1'b1) begin n_errors++; $display("FAIL waw_issue: got %b expected 1", flt_insert_en); end
      tick();
      @(negedge clk);
      n_checks++; if (out_tag !== 4'd0) begin n_errors++; $display("FAIL waw_tag: got %0d expected 0", out_tag); end
      n_checks++; if (out_addr !== 32'h0011_0010) begin n_errors++; $display("FAIL waw_addr: got %h expected 00110010", out_addr); end
      n_checks++; if (out_isWrite !== 1'b1) begin n_errors++; $display("FAIL waw_wr: got %b expected 1", out_isWrite); end
      tick();
      free_tags(1);
   endtask

   task automatic test_read_after_write();
      req_addr = 32'h3; req_isWrite = 1'b1; req_valid = 1'b1;
      tick();
      req_addr = 32'h30; req_isWrite = 1'b0;
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (flt_test_req !== 4'd3) begin n_errors++; $display("FAIL raw_test_req: got %0d expected 3", flt_test_req); end
      n_checks++; if (flt_insert_en !== 1'b0) begin n_errors++; $display("FAIL raw_held: got %b expected 0", flt_insert_en); end
      repeat (2) tick();
      rsp_tag = 4'd0; rsp_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (flt_remove !== 4'd3) begin n_errors++; $display("FAIL raw_remove: got %0d expected 3", flt_remove); end
      n_checks++; if (flt_insert_en !== 1'b0) begin n_errors++; $display("FAIL raw_rsp_cycle: got %b expected 0", flt_insert_en); end
      tick();
      rsp_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (flt_insert_en !== 1'b1) begin n_errors++; $display("FAIL raw_issue: got %b expected 1", flt_insert_en); end
      tick();
      @(negedge clk);
      n_checks++; if (out_addr !== 32'h30) begin n_errors++; $display("FAIL raw_addr: got %h expected 30", out_addr); end
      n_checks++; if (out_tag !== 4'd0) begin n_errors++; $display("FAIL raw_tag: got %0d expected 0", out_tag); end
      tick();
      free_tags(1);
   endtask

   task automatic test_tag_exhaustion();
      req_isWrite = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         req_addr  = (i < 16) ? 32'(i) : 32'h40;
         req_valid = 1'b1;
         tick();
         @(negedge clk);
         if (i >= 1) begin
            n_checks++; if (out_tag !== 4'(i - 1)) begin n_errors++; $display("FAIL exh_tag_%0d: got %0d expected %0d", i, out_tag, i - 1); end
         end
      end
      req_valid = 1'b0;
      n_checks++; if (flt_insert_en !== 1'b0) begin n_errors++; $display("FAIL exh_17th_held: got %b expected 0", flt_insert_en); end
      tick();
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL exh_no_out: got %b expected 0", out_valid); end
      tick();
      rsp_tag = 4'd5; rsp_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (flt_remove !== 4'd5) begin n_errors++; $display("FAIL exh_remove: got %0d expected 5", flt_remove); end
      n_checks++; if (flt_insert_en !== 1'b0) begin n_errors++; $display("FAIL exh_same_cycle: got %b expected 0", flt_insert_en); end
      tick();
      rsp_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (flt_insert_en !== 1'b1) begin n_errors++; $display("FAIL exh_issue: got %b expected 1", flt_insert_en); end
      n_checks++; if (flt_insert !== 4'd4) begin n_errors++; $display("FAIL exh_insert: got %0d expected 4", flt_insert); end
      tick();
      @(negedge clk);
      n_checks++; if (out_tag !== 4'd5) begin n_errors++; $display("FAIL exh_freed_tag: got %0d expected 5", out_tag); end
      n_checks++; if (out_addr !== 32'h40) begin n_errors++; $display("FAIL exh_addr: got %h expected 40", out_addr); end
      tick();
      free_tags(16);
   endtask

   task automatic test_back_pressure();
      out_ready = 1'b0; req_isWrite = 1'b0;
      req_addr = 32'h1; req_valid = 1'b1;
      tick();
      req_addr = 32'h2;
      tick();
      @(negedge clk);
      n_checks++; if (out_addr !== 32'h1) begin n_errors++; $display("FAIL bp_out_addr_first: got %h expected 1", out_addr); end
      req_addr = 32'h3;
      tick();
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_mid: got %b expected 1", req_ready); end
      req_addr = 32'h4;
      tick();
      req_addr = 32'h5;
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full: got %b expected 0", req_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
      n_checks++; if (out_addr !== 32'h1) begin n_errors++; $display("FAIL bp_out_addr_held: got %h expected 1", out_addr); end
      n_checks++; if (out_tag !== 4'd0) begin n_errors++; $display("FAIL bp_out_tag_held: got %0d expected 0", out_tag); end
      n_checks++; if (flt_insert_en !== 1'b0) begin n_errors++; $display("FAIL bp_no_issue: got %b expected 0", flt_insert_en); end
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (flt_insert !== 4'd2) begin n_errors++; $display("FAIL bp_resume_insert: got %0d expected 2", flt_insert); end
      tick();
      @(negedge clk);
      n_checks++; if (out_addr !== 32'h2) begin n_errors++; $display("FAIL bp_resume_addr: got %h expected 2", out_addr); end
      n_checks++; if (out_tag !== 4'd1) begin n_errors++; $display("FAIL bp_resume_tag: got %0d expected 1", out_tag); end
      n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_again: got %b expected 1", req_ready); end
      repeat (4) tick();
      free_tags(5);
   endtask

   task automatic test_bad_tag();
      rsp_tag = 4'd7; rsp_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (flt_remove_en !== 1'b0) begin n_errors++; $display("FAIL bad_no_remove: got %b expected 0", flt_remove_en); end
      tick();
      rsp_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (err_badTag !== 1'b1) begin n_errors++; $display("FAIL bad_err_set: got %b expected 1", err_badTag); end
      repeat (3) tick();
      @(negedge clk);
      n_checks++; if (err_badTag !== 1'b1) begin n_errors++; $display("FAIL bad_err_sticky: got %b expected 1", err_badTag); end
      tick();
   endtask

   task automatic test_reset_mid();
      req_isWrite = 1'b0; req_valid = 1'b1;
      req_addr = 32'h6; tick();
      req_addr = 32'h7; tick();
      req_addr = 32'h8; tick();
      req_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (out_addr !== 32'h0) begin n_errors++; $display("FAIL mid_out_addr: got %h expected 0", out_addr); end
      n_checks++; if (flt_insert_en !== 1'b0) begin n_errors++; $display("FAIL mid_insert_en: got %b expected 0", flt_insert_en); end
      n_checks++; if (err_badTag !== 1'b0) begin n_errors++; $display("FAIL mid_err: got %b expected 0", err_badTag); end
      n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL mid_ready: got %b expected 0", req_ready); end
      tick();
      reset = 1'b0;
      req_addr = 32'h9; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (flt_insert_en !== 1'b1) begin n_errors++; $display("FAIL mid_issue: got %b expected 1", flt_insert_en); end
      tick();
      @(negedge clk);
      n_checks++; if (out_tag !== 4'd0) begin n_errors++; $display("FAIL mid_tag: got %0d expected 0", out_tag); end
      n_checks++; if (out_addr !== 32'h9) begin n_errors++; $display("FAIL mid_addr: got %h expected 9", out_addr); end
      tick();
   endtask

   initial begin
      reset = 1'b1; req_addr = '0; req_isWrite = 1'b0; req_valid = 1'b0;
      out_ready = 1'b1; rsp_tag = '0; rsp_valid = 1'b0;
      test_reset();
      test_basic_read();
      test_write_after_write();
      test_read_after_write();
      test_tag_exhaustion();
      test_back_pressure();
      test_bad_tag();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
